// File: rtl/board_io_conditioner.sv
// board_io_conditioner: PLL-lock reset stretcher plus per-channel button debouncer with press/release pulses.
module board_io_conditioner #(
  parameter int N_BTN = 7,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int RST_CYC = 16,
  parameter logic [N_BTN-1:0] BTN_INV = N_BTN'(7'b0000001)
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic [N_BTN-1:0] btn_in,
  output logic             sys_reset,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RST_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  logic [1:0] lock_sync;
  logic [N_BTN-1:0] btn_s1, btn_s2, raw, flip;
  logic [RW-1:0] rst_cnt;
  logic [DW-1:0] db_cnt [N_BTN];
  logic clr;
  always_ff @(posedge clk_25mhz) begin
    lock_sync <= {lock_sync[0], pll_locked};
    btn_s1 <= btn_in;
    btn_s2 <= btn_s1;
  end
  always_ff @(posedge clk_25mhz) begin
    if (reset || !lock_sync[1]) rst_cnt <= '0;
    else if (rst_cnt != RST_MAX) rst_cnt <= rst_cnt + 1'b1;
    sys_reset <= reset || (rst_cnt < RST_MAX);
  end
  assign raw = btn_s2 ^ BTN_INV;
  assign clr = reset || sys_reset;
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++) flip[i] = (raw[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
  end
  // a flip and its pulse land on the same edge, so pulses coincide with the level change
  always_ff @(posedge clk_25mhz) begin
    if (clr) begin
      btn_level <= '0;
      btn_press <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_level <= btn_level ^ flip;
      btn_press <= flip & raw;
      btn_release <= flip & ~raw;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= (raw[i] == btn_level[i] || flip[i]) ? '0 : db_cnt[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner: directed checks of reset stretch, lock loss and debounce timing.
module tb_board_io_conditioner;
  logic clk_25mhz = 1'b0;
  logic reset, pll_locked;
  logic [6:0] btn_in, btn_level, btn_press, btn_release;
  logic sys_reset;
  int tests = 0, fails = 0;
  logic seen;
  board_io_conditioner #(.N_BTN(7), .DEBOUNCE_CYC(8), .RST_CYC(16), .BTN_INV(7'b0000001)) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .pll_locked(pll_locked), .btn_in(btn_in),
    .sys_reset(sys_reset), .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );
  always #20 clk_25mhz = ~clk_25mhz;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
  endtask
  task automatic watch(input int n);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      seen = seen | (|btn_press) | (|btn_release) | (|btn_level);
    end
  endtask
  initial begin
    reset = 1'b1; pll_locked = 1'b1; btn_in = 7'b0000001;
    @(negedge clk_25mhz);
    for (int k = 0; k < 3; k++) step();
    check("rst_sys", 32'(sys_reset), 32'(1));
    check("rst_lvl", 32'(btn_level), 32'(0));
    check("rst_prs", 32'(btn_press), 32'(0));
    check("rst_rel", 32'(btn_release), 32'(0));
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      check("stretch", 32'(sys_reset), 32'(k < 17));
    end
    btn_in[3] = 1'b1;
    for (int k = 0; k < 7; k++) step();
    btn_in[3] = 1'b0;
    watch(20);
    check("glitch", 32'(seen), 32'(0));
    btn_in[3] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("lvl3_up", 32'(btn_level[3]), 32'(k >= 10));
      check("prs3", 32'(btn_press), 32'(k == 10 ? 8 : 0));
    end
    btn_in[3] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("lvl3_dn", 32'(btn_level[3]), 32'(k < 10));
      check("rel3", 32'(btn_release), 32'(k == 10 ? 8 : 0));
    end
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("lvl0", 32'(btn_level[0]), 32'(k >= 10));
      check("prs0", 32'(btn_press), 32'(k == 10 ? 1 : 0));
    end
    btn_in[0] = 1'b1;
    for (int k = 0; k < 12; k++) step();
    check("lvl0_idle", 32'(btn_level), 32'(0));
    btn_in = 7'b0100011;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("prs15", 32'(btn_press), 32'(k == 10 ? 7'b0100010 : 0));
    end
    btn_in = 7'b0000001;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("rel15", 32'(btn_release), 32'(k == 10 ? 7'b0100010 : 0));
    end
    btn_in[2] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1; btn_in[2] = 1'b0;
    for (int k = 0; k < 2; k++) step();
    reset = 1'b0;
    watch(40);
    check("mid_rst", 32'(seen), 32'(0));
    btn_in[2] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_lvl2", 32'(btn_level), 32'(0));
    end
    reset = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      step();
      check("held_sys", 32'(sys_reset), 32'(k < 17));
      check("held_prs", 32'(btn_press), 32'(k == 25 ? 4 : 0));
    end
    btn_in[2] = 1'b0;
    for (int k = 0; k < 12; k++) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    check("lock_k1", 32'(sys_reset), 32'(0));
    for (int k = 2; k <= 22; k++) begin
      step();
      check("lock_drop", 32'(sys_reset), 32'(k >= 4 && k < 20));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
